// File: rtl/fsqrt_wb_stage_pkg.sv
// Shared FPU post-stage definitions: fsqrt operand classes, IEEE-754 single constants
// and the classifier used by the fsqrt writeback fix-up and sibling stages.
package fsqrt_wb_stage_pkg;

  typedef enum logic [1:0] {
    FSQRT_CLS_NORM = 2'd0,
    FSQRT_CLS_ZERO = 2'd1,
    FSQRT_CLS_QNAN = 2'd2,
    FSQRT_CLS_PINF = 2'd3
  } fsqrt_cls_e;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF     = 32'h7F80_0000;
  localparam logic [7:0]  FP_EXP_ONES = 8'hFF;
  localparam logic [7:0]  FP_EXP_ZERO = 8'h00;

  // Denormals count as zero; any negative non-zero operand has no real root.
  function automatic fsqrt_cls_e fsqrt_classify(input logic [31:0] a);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = a[31];
    e = a[30:23];
    m = a[22:0];
    if (e == FP_EXP_ZERO)
      return FSQRT_CLS_ZERO;
    else if (s || (e == FP_EXP_ONES && m != '0))
      return FSQRT_CLS_QNAN;
    else if (e == FP_EXP_ONES)
      return FSQRT_CLS_PINF;
    else
      return FSQRT_CLS_NORM;
  endfunction

endpackage

// File: rtl/fsqrt_wb_stage_if.sv
// Issue and writeback handshake bundle of the fsqrt writeback stage.
interface fsqrt_wb_stage_if #(
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/fsqrt_wb_fifo.sv
// Shift-style result FIFO whose head register drives the writeback outputs directly;
// the head holds its last value when the FIFO drains.
module fsqrt_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    wr_idx;

  always_comb begin
    mem_d   = mem_q;
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);
    wr_idx  = cnt_q - CW'(pop_ok);
    // Popping the only entry leaves the head in place so the outputs hold.
    if (pop_ok && cnt_q > CW'(1)) begin
      for (int i = 0; i < DEPTH - 1; i++)
        mem_d[i] = mem_q[i+1];
    end
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == CW'(i))
          mem_d[i] = data_i;
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (clr_i) begin
      mem_d = mem_q;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mem_q[0] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[0];
  assign count_o = cnt_q;

endmodule

// File: rtl/fsqrt_wb_stage.sv
// fsqrt writeback stage: credit-limited issue into a non-stallable core, shadow pipe
// tracking valid/tag/class, IEEE special-case fix-up and a result FIFO.
module fsqrt_wb_stage
  import fsqrt_wb_stage_pkg::*;
#(
  parameter int CORE_LAT = 2,
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  fsqrt_wb_stage_if.slave      bus,
  output logic [31:0]          core_a,
  input  logic [31:0]          core_result
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(CORE_LAT + 1);
  localparam int SW = $clog2(DEPTH + CORE_LAT + 1);
  localparam int EW = 32 + TAG_W;

  logic             sh_vld_q [CORE_LAT];
  logic             sh_vld_d [CORE_LAT];
  logic [TAG_W-1:0] sh_tag_q [CORE_LAT];
  logic [TAG_W-1:0] sh_tag_d [CORE_LAT];
  fsqrt_cls_e       sh_cls_q [CORE_LAT];
  fsqrt_cls_e       sh_cls_d [CORE_LAT];
  logic             sh_sgn_q [CORE_LAT];
  logic             sh_sgn_d [CORE_LAT];

  logic [IW-1:0]    inflight;
  logic [SW-1:0]    used;
  logic             in_rdy;
  logic             accept;
  logic             cap_vld;
  logic [31:0]      cap_res;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_vld;
  logic [EW-1:0]    fifo_head;

  function automatic logic [31:0] fsqrt_fixup(input fsqrt_cls_e cls, input logic sgn,
                                              input logic [31:0] res);
    case (cls)
      FSQRT_CLS_ZERO: return {sgn, 31'b0};
      FSQRT_CLS_QNAN: return FP_QNAN;
      FSQRT_CLS_PINF: return FP_PINF;
      default:        return res;
    endcase
  endfunction

  // Credits cover both in-flight core ops and buffered results, so a capture always fits.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CORE_LAT; i++)
      inflight = inflight + IW'(sh_vld_q[i]);
  end

  assign used   = SW'(inflight) + SW'(fifo_cnt);
  assign in_rdy = ~rst & ~flush & (used < SW'(DEPTH));
  assign accept = bus.in_valid & in_rdy;
  assign core_a = bus.in_a;

  // Stage 1 of the shadow pipe is loaded at the accept edge, alongside the core's first stage.
  always_comb begin
    sh_vld_d[0] = accept;
    sh_tag_d[0] = bus.in_tag;
    sh_cls_d[0] = fsqrt_classify(bus.in_a);
    sh_sgn_d[0] = bus.in_a[31];
    for (int i = 1; i < CORE_LAT; i++) begin
      sh_vld_d[i] = sh_vld_q[i-1];
      sh_tag_d[i] = sh_tag_q[i-1];
      sh_cls_d[i] = sh_cls_q[i-1];
      sh_sgn_d[i] = sh_sgn_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < CORE_LAT; i++)
        sh_vld_q[i] <= 1'b0;
    end else begin
      sh_vld_q <= sh_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_tag_q <= sh_tag_d;
    sh_cls_q <= sh_cls_d;
    sh_sgn_q <= sh_sgn_d;
  end

  // Shadow tail lines up with core_result; flushed ops arrive here with valid cleared.
  assign cap_vld = sh_vld_q[CORE_LAT-1];
  assign cap_res = fsqrt_fixup(sh_cls_q[CORE_LAT-1], sh_sgn_q[CORE_LAT-1], core_result);

  fsqrt_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (rst | flush),
    .push_i  (cap_vld),
    .data_i  ({sh_tag_q[CORE_LAT-1], cap_res}),
    .pop_i   (bus.out_ready),
    .valid_o (fifo_vld),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = fifo_vld;
  assign bus.out_data  = fifo_head[31:0];
  assign bus.out_tag   = fifo_head[32 +: TAG_W];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(cap_vld && fifo_cnt == CW'(DEPTH)));

endmodule

// File: tb/tb_fsqrt_wb_stage.sv
// Scoreboard bench for fsqrt_wb_stage with a 2-stage behavioural fsqrt core.
module tb_fsqrt_wb_stage;
  localparam int CORE_LAT = 2;
  localparam int DEPTH    = 4;
  localparam int TAG_W    = 6;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fsqrt_wb_stage_if #(.TAG_W(TAG_W)) bus ();

  logic [31:0] core_a;
  logic [31:0] core_result;
  logic [31:0] core_s1;
  logic        garbage = 1'b0;

  fsqrt_wb_stage #(
    .CORE_LAT (CORE_LAT),
    .DEPTH    (DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .core_a      (core_a),
    .core_result (core_result)
  );

  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic g);
    if (g) return 32'h1234_5678;
    if (a == 32'h4080_0000) return 32'h4000_0000;
    return a ^ 32'h0F0F_0F0F;
  endfunction

  always @(posedge clk) begin
    core_s1     <= core_fn(core_a, garbage);
    core_result <= core_s1;
  end

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] cur_exp;
  int          n_chk = 0;
  int          n_err = 0;

  logic [31:0] sp_a [6] = '{32'h0000_0000, 32'h8000_0000, 32'h0040_0000,
                            32'hBF80_0000, 32'h7F80_0000, 32'h7FC0_0001};
  logic [31:0] sp_e [6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000,
                            32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    sb_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready && !rst) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(bus.out_data), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("out_data", 64'(bus.out_data), 64'(e.data));
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
      end
    end
    if (rst || flush)
      sb.delete();
    else if (bus.in_valid && bus.in_ready === 1'b1)
      sb.push_back({bus.in_tag, cur_exp});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [TAG_W-1:0] t, input logic [31:0] e);
    bus.in_a   = a;
    bus.in_tag = t;
    cur_exp    = e;
  endtask

  task automatic issue(input logic [31:0] a, input logic [TAG_W-1:0] t, input logic [31:0] e);
    bit ok;
    ok = 1'b0;
    set_op(a, t, e);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("issue_timeout", 64'(ok), 64'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  function automatic logic [31:0] norm_op(input int k);
    return 32'h3F80_0000 + (32'(k) << 16);
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, acc, stalls, vcnt, first, last, seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    cur_exp       = '0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_tag", 64'(bus.out_tag), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Single issue and latency
    tick();
    set_op(32'h4080_0000, 6'h15, 32'h4000_0000);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("single_latency", 64'(lat), 64'(CORE_LAT));
    check("single_data", 64'(bus.out_data), 64'h4000_0000);
    check("single_tag", 64'(bus.out_tag), 64'h15);
    drain();

    // IEEE specials with a garbage core result
    garbage = 1'b1;
    for (int i = 0; i < 6; i++)
      issue(sp_a[i], 6'(i + 1), sp_e[i]);
    drain();
    garbage = 1'b0;

    // Back-pressure: credits stop issue at DEPTH
    bus.out_ready = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_op(norm_op(acc), 6'(acc + 8), core_fn(norm_op(acc), 1'b0));
      @(negedge clk);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_accepts", 64'(acc), 64'(DEPTH));
    @(negedge clk);
    check("bp_in_ready_full", 64'(bus.in_ready), 64'(0));
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_pop_cycle", 64'(bus.in_ready), 64'(0));
    check("bp_out_valid", 64'(bus.out_valid), 64'(1));
    tick();
    check("bp_in_ready_return", 64'(bus.in_ready), 64'(1));
    drain();

    // Full-rate streaming
    stalls = 0; vcnt = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        set_op(norm_op(c + 20), 6'(c + 16), core_fn(norm_op(c + 20), 1'b0));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready) stalls++;
      if (bus.out_valid) begin
        vcnt++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    check("stream_stalls", 64'(stalls), 64'(0));
    check("stream_count", 64'(vcnt), 64'(16));
    check("stream_no_gaps", 64'(last - first + 1), 64'(16));
    drain();

    // Flush with 2 in flight and 2 buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(norm_op(i + 40), 6'(i + 48), core_fn(norm_op(i + 40), 1'b0));
    set_op(norm_op(50), 6'h3F, core_fn(norm_op(50), 1'b0));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'(0));
    check("flush_prebuffered", 64'(bus.out_valid), 64'(1));
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_fifo_empty", 64'(bus.out_valid), 64'(0));
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
      tick();
    end
    check("flush_dropped", 64'(seen), 64'(0));
    bus.out_ready = 1'b1;
    issue(norm_op(60), 6'h2A, core_fn(norm_op(60), 1'b0));
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("post_flush_tag", 64'(bus.out_tag), 64'h2A);
    drain();

    // Reset during streaming
    for (int i = 0; i < 5; i++)
      issue(norm_op(i + 70), 6'(i + 1), core_fn(norm_op(i + 70), 1'b0));
    set_op(norm_op(80), 6'h07, core_fn(norm_op(80), 1'b0));
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_out_data", 64'(bus.out_data), 64'(0));
    check("midrst_out_tag", 64'(bus.out_tag), 64'(0));
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_back", 64'(bus.in_ready), 64'(1));
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst_no_stale", 64'(seen), 64'(0));
    tick();
    bus.out_ready = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_op(norm_op(acc + 90), 6'(acc + 33), core_fn(norm_op(acc + 90), 1'b0));
      @(negedge clk);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("midrst_credits", 64'(acc), 64'(DEPTH));
    drain();

    check("sb_final_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fsqrt_wb_stage.md
Name: fsqrt_wb_stage

Overview:
- Downstream companion of the 2-clock table-based fsqrt pipeline.
- Accepts fsqrt issue requests (operand + destination tag) with a valid/ready handshake and drives the operand straight into the core.
- Carries valid/tag/special-class bits in a shadow pipe aligned with the core latency, fixes up IEEE special cases the core does not handle, and buffers results in a small FIFO toward the FPU writeback arbiter.
- The core cannot stall, so issue is credit-limited so that no result is ever dropped.

Parameters:
- CORE_LAT, 2, edges from the accept edge to the edge after which core_result is valid, plus one (core_result is valid in the cycle following edge E0+CORE_LAT-1).
- DEPTH, 4, result FIFO entries; also the total credit limit (in-flight + buffered).
- TAG_W, 6, width of the destination register tag.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch mispredict/trap).
- in_valid  in  1  issue request valid.
- in_ready  out  1  issue accepted when in_valid & in_ready at posedge.
- in_a  in  32  single-precision operand.
- in_tag  in  TAG_W  destination tag.
- core_a  out  32  operand to the fsqrt core; combinationally equal to in_a.
- core_result  in  32  fsqrt core registered result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  writeback arbiter takes head when out_valid & out_ready.
- out_data  out  32  result word.
- out_tag  out  TAG_W  destination tag of result.

Behaviour:
- Reset (rst=1 at posedge): all shadow valids 0, FIFO empty, credit count 0.
  - out_valid=0, out_data=0, out_tag=0.
  - in_ready=0 during the reset cycle, 1 afterwards.
- Accept: at edge E0 with in_valid & in_ready, push {1, in_tag, cls} into shadow stage 1; the shadow pipe is CORE_LAT deep.
- Classification of in_a: sign s, exponent e, mantissa m.
  - ZERO: e==0 (denormals flush). Result {s, 31'b0}.
  - QNAN: s==1 & e!=0, or e==8'hFF & m!=0. Result 32'h7FC00000.
  - PINF: s==0 & e==8'hFF & m==0. Result 32'h7F800000.
  - NORM: otherwise. Result core_result unchanged.
- Capture: at edge E0+CORE_LAT, the shadow tail with valid=1 writes {fixed-up result, tag} into the FIFO.
  - Issue-to-out_valid latency is CORE_LAT cycles when the FIFO was empty.
- Back-to-back issue at 1/cycle is sustained while credits remain; results leave in issue order.
- Credits: in_ready = ~rst & ~flush & ((inflight + fifo_count) < DEPTH).
  - Computed from registers only; no combinational path from in_valid or out_ready.
  - inflight = number of valid shadow entries.
  - Simultaneous accept, capture and pop in one cycle are all legal; counts update by the net effect.
- FIFO full: cannot overflow by construction. An assertion flags a capture with fifo_count==DEPTH.
- FIFO empty: out_valid=0. out_data/out_tag hold their last value; only out_valid qualifies them.
- Pop: out_ready with out_valid=0 is ignored.
- out_data, out_tag and out_valid come from the FIFO head register (registered outputs).
- Flush (at posedge): clears all shadow valids and empties the FIFO.
  - in_valid in the flush cycle is not accepted.
  - A core result arriving later for a flushed op is discarded, because its shadow valid is 0.
  - The core itself is not flushed.
- Reset mid-operation: identical to flush, plus the output registers clear.

Decomposition:
- Shared fpu package:
  - FSQRT_CLS_NORM/ZERO/QNAN/PINF 2-bit class encodings.
  - FP_QNAN=32'h7FC00000, FP_PINF=32'h7F800000.
  - Exponent all-ones/zero constants.
  - A classify function reused by other FPU post-stages.
- One sub-module, fsqrt_wb_fifo:
  - Parameterised DEPTH, width 32+TAG_W.
  - Synchronous clear input driven by rst|flush.
  - count output.
- The shadow pipe and fix-up mux stay in the top.

Test Plan:
- Single issue, in_a=32'h40800000 (4.0), core model returns 32'h40000000 -> out_valid exactly CORE_LAT cycles after accept, out_data=32'h40000000, out_tag echoes in_tag.
- Specials: in_a = 32'h00000000, 32'h80000000, 32'h00400000, 32'hBF800000, 32'h7F800000, 32'h7FC00001, with core returning garbage 32'h12345678 -> outputs are, respectively:
  - 32'h00000000
  - 32'h80000000
  - 32'h00000000
  - 32'h7FC00000
  - 32'h7F800000
  - 32'h7FC00000
- Back-pressure: out_ready=0, issue continuously -> exactly DEPTH=4 accepts, then in_ready=0; raise out_ready -> 4 results drain in order, in_ready returns the cycle after the first pop.
- Full-rate streaming: 16 back-to-back issues with out_ready=1 -> in_ready stays 1 and there are 16 in-order results with no gaps.
- Flush with 2 in flight and 2 buffered -> FIFO empty next cycle, the two later core results are dropped, and a new issue after flush completes normally with the correct tag.
- Reset asserted during streaming -> all outputs 0 and credits restored to DEPTH; no stale result appears after reset.
